// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink sequencer: FSM state encoding.
package led_blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear and increment may coincide.
module bsg_counter_clear_up #(
    parameter int unsigned max_val_p   = 8,
    parameter int unsigned init_val_p  = 0,
    parameter int unsigned ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_n;

    always_comb begin
        count_n = clear_i ? '0 : count_o;
        if (up_i)
            count_n = count_n + ptr_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            count_o <= ptr_width_lp'(init_val_p);
        else
            count_o <= count_n;
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// Turns event strobes into one visible blink each (fixed on/off time), queueing
// events that arrive mid-blink in a saturating pending counter.
module led_blink_sequencer
    import led_blink_pkg::*;
#(
    parameter int unsigned width_p         = 11,
    parameter int unsigned pending_width_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pulse_i,
    output logic                       led_o,
    output logic                       busy_o,
    output logic [pending_width_p-1:0] pending_o,
    output logic                       overflow_o
);

    localparam int unsigned phase_len_lp = 1 << width_p;
    localparam logic [width_p:0] terminal_lp = (width_p + 1)'(phase_len_lp - 1);

    state_e           state, state_n;
    logic             pulse_r;
    logic             event_w;
    logic [width_p:0] timer;
    logic             timer_clear, timer_up;
    logic             terminal;
    logic             starts_blink;
    logic             inc, dec;

    bsg_counter_clear_up #(
        .max_val_p (phase_len_lp),
        .init_val_p(0)
    ) phase_timer (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(timer_clear),
        .up_i   (timer_up),
        .count_o(timer)
    );

    assign event_w  = pulse_i & ~pulse_r;
    assign terminal = (timer == terminal_lp);

    // A blink started by a fresh event consumes it; one started from the queue
    // decrements pending, and a coincident event re-increments it.
    always_comb begin
        state_n      = state;
        timer_clear  = 1'b0;
        timer_up     = 1'b0;
        starts_blink = 1'b0;
        dec          = 1'b0;
        unique case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (event_w) begin
                    state_n      = ON;
                    starts_blink = 1'b1;
                end
            end
            ON: begin
                if (terminal) begin
                    state_n     = OFF;
                    timer_clear = 1'b1;
                end else begin
                    timer_up = 1'b1;
                end
            end
            OFF: begin
                if (terminal) begin
                    timer_clear = 1'b1;
                    if (pending_o != '0) begin
                        state_n = ON;
                        dec     = 1'b1;
                    end else if (event_w) begin
                        state_n      = ON;
                        starts_blink = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_up = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                timer_clear = 1'b1;
            end
        endcase
    end

    assign inc = event_w & ~starts_blink;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            led_o      <= 1'b0;
            pulse_r    <= 1'b0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state   <= state_n;
            led_o   <= (state_n == ON);
            pulse_r <= pulse_i;
            if (inc && !dec) begin
                if (pending_o == '1)
                    overflow_o <= 1'b1;
                else
                    pending_o <= pending_o + pending_width_p'(1);
            end else if (dec && !inc) begin
                pending_o <= pending_o - pending_width_p'(1);
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer with 8-cycle phases and a 2-bit pending queue.
module tb_led_blink_sequencer;

    localparam int W    = 3;
    localparam int PW   = 2;
    localparam int PH   = 8;
    localparam int MAXP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse;
    logic          led, busy, ovf;
    logic [PW-1:0] pend;

    always #5 clk = ~clk;

    led_blink_sequencer #(
        .width_p        (W),
        .pending_width_p(PW)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .pulse_i   (pulse),
        .led_o     (led),
        .busy_o    (busy),
        .pending_o (pend),
        .overflow_o(ovf)
    );

    // Reference: a blink is a 2*PH-cycle window; position < PH means LED on.
    bit m_prev, m_active, m_ovf;
    int m_pos, m_pend;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit pulse;
        bit led;
        bit busy;
        int pend;
        bit ovf;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_prev = 0; m_active = 0; m_ovf = 0; m_pos = 0; m_pend = 0;
    endfunction

    function automatic void model_step(input bit p);
        bit ev;
        ev = p & ~m_prev;
        m_prev = p;
        if (!m_active) begin
            if (ev) begin
                m_active = 1;
                m_pos = 0;
            end
        end else if (m_pos == 2*PH - 1) begin
            if (m_pend > 0) begin
                m_pos = 0;
                if (!ev) m_pend--;
            end else if (ev) begin
                m_pos = 0;
            end else begin
                m_active = 0;
            end
        end else begin
            m_pos++;
            if (ev) begin
                if (m_pend == MAXP) m_ovf = 1;
                else m_pend++;
            end
        end
    endfunction

    task automatic check_model();
        check("led",      int'(led),  int'(m_active && m_pos < PH));
        check("busy",     int'(busy), int'(m_active));
        check("pending",  int'(pend), m_pend);
        check("overflow", int'(ovf),  int'(m_ovf));
    endtask

    task automatic tick(input bit p);
        pulse = p;
        @(posedge clk);
        model_step(p);
        #1;
        check_model();
    endtask

    int blinks, on_cycles;
    bit led_prev;

    initial begin
        rst   = 1'b1;
        pulse = 1'b0;
        model_reset();
        #12;
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        // Single one-cycle pulse from IDLE: 8 on, 8 off, then idle.
        for (int i = 0; i < 20; i++) begin
            tbl[i].pulse = (i == 0);
            tbl[i].led   = (i < PH);
            tbl[i].busy  = (i < 2*PH);
            tbl[i].pend  = 0;
            tbl[i].ovf   = 0;
        end
        for (int i = 0; i < 20; i++) begin
            pulse = tbl[i].pulse;
            @(posedge clk);
            model_step(tbl[i].pulse);
            #1;
            check("tbl_led",  int'(led),  int'(tbl[i].led));
            check("tbl_busy", int'(busy), int'(tbl[i].busy));
            check("tbl_pend", int'(pend), tbl[i].pend);
            check("tbl_ovf",  int'(ovf),  int'(tbl[i].ovf));
        end

        // Level held high counts once.
        blinks = 0; led_prev = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1);
            if (led && !led_prev) blinks++;
            led_prev = led;
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (led && !led_prev) blinks++;
            led_prev = led;
        end
        check("held_blinks", blinks, 1);

        // Three separated pulses: queue reaches 2, three back-to-back blinks.
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        check("pend_two", int'(pend), 2);
        for (int i = 0; i < 60; i++) tick(1'b0);
        check("three_idle", int'(busy), 0);

        // Five events in the first ON phase: saturate, overflow, four blinks.
        blinks = 0; led_prev = 0;
        for (int i = 0; i < 9; i++) begin
            tick(i % 2 == 0);
            if (led && !led_prev) blinks++;
            led_prev = led;
        end
        check("sat_pend", int'(pend), MAXP);
        check("sat_ovf", int'(ovf), 1);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0);
            if (led && !led_prev) blinks++;
            led_prev = led;
        end
        check("sat_blinks", blinks, 4);
        check("ovf_sticky", int'(ovf), 1);

        // Event exactly on OFF terminal, nothing queued.
        tick(1'b1);
        for (int i = 0; i < 15; i++) tick(1'b0);
        tick(1'b1);
        check("term0_led", int'(led), 1);
        check("term0_pend", int'(pend), 0);
        for (int i = 0; i < 40; i++) tick(1'b0);

        // Event exactly on OFF terminal with one queued.
        tick(1'b1); tick(1'b0); tick(1'b1);
        for (int i = 0; i < 13; i++) tick(1'b0);
        tick(1'b1);
        check("term1_led", int'(led), 1);
        check("term1_pend", int'(pend), 1);
        for (int i = 0; i < 50; i++) tick(1'b0);

        // Asynchronous reset mid-ON, between edges.
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_led", int'(led), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pend", int'(pend), 0);
        check("arst_ovf", int'(ovf), 0);
        model_reset();
        rst = 1'b0;
        on_cycles = 0;
        tick(1'b1);
        if (led) on_cycles++;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (led) on_cycles++;
        end
        check("post_rst_on", on_cycles, PH);

        // Random traffic against the reference.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 5) == 0);
        for (int i = 0; i < 200; i++)
            tick($urandom_range(0, 1) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
